// File: rtl/airlock_pkg.sv
// ---------------------------------------------------------------------------
// airlock_pkg
// Definitions shared by the airlock stages (fill-and-pressurize and
// drain-and-depressurize):
//   airlock_state_e       3-bit state encoding common to both stages
//   DEFAULT_DRAIN_CYCLES  default drain pump run time, in cycles
//   DEFAULT_VENT_TIMEOUT  default maximum time spent venting, in cycles
//   max_int()             elaboration-time helper for sizing counters
// ---------------------------------------------------------------------------
package airlock_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DRAIN = 3'd1,
        VENT  = 3'd2,
        DONE  = 3'd3,
        FAULT = 3'd4
    } airlock_state_e;

    localparam int DEFAULT_DRAIN_CYCLES = 8;
    localparam int DEFAULT_VENT_TIMEOUT = 16;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/drain_and_depressurize_if.sv
// ---------------------------------------------------------------------------
// drain_and_depressurize_if
// Sequencer/sensor bundle for the drain-and-depressurize stage.
//   begin_DandD    request from the sequencer
//   FandP          done flag from the upstream fill-and-pressurize stage
//   InnerClosed    inner door sensor, 1 = closed
//   OuterClosed    outer door sensor, 1 = closed
//   Depressurized  pressure sensor, 1 = chamber at ambient
//   Draining       drain pump enable
//   Venting        vent valve enable
//   DandD          cycle complete
//   Fault          sticky error
// master: the sequencer/plant side; slave: the drain-and-depressurize stage.
// ---------------------------------------------------------------------------
interface drain_and_depressurize_if;

    logic begin_DandD;
    logic FandP;
    logic InnerClosed;
    logic OuterClosed;
    logic Depressurized;
    logic Draining;
    logic Venting;
    logic DandD;
    logic Fault;

    modport master (
        output begin_DandD, FandP, InnerClosed, OuterClosed, Depressurized,
        input  Draining, Venting, DandD, Fault
    );

    modport slave (
        input  begin_DandD, FandP, InnerClosed, OuterClosed, Depressurized,
        output Draining, Venting, DandD, Fault
    );

endinterface

// File: rtl/cycle_counter.sv
// ---------------------------------------------------------------------------
// cycle_counter
// Free-running interval counter shared by the drain and vent intervals.
//   Clock   rising-edge clock
//   clear   synchronous clear to zero (wins over enable)
//   enable  increment by one this cycle
//   count   current count
// The parent folds its synchronous reset into clear, so this block needs no
// reset port of its own.
// ---------------------------------------------------------------------------
module cycle_counter #(
    parameter int WIDTH = 4
) (
    input  logic             Clock,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // NOTE: the default assignment first keeps this block purely
    // combinational; a missing else-path would otherwise infer a latch.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // NOTE: non-blocking assignment so every flop samples the pre-edge value.
    always_ff @(posedge Clock) begin
        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/drain_and_depressurize.sv
// ---------------------------------------------------------------------------
// drain_and_depressurize
// Airlock stage that drains the chamber for DRAIN_CYCLES, then vents until
// the pressure sensor reports ambient (or VENT_TIMEOUT expires). Any door
// opening while draining or venting latches a sticky fault.
//   Clock  rising-edge clock
//   Reset  synchronous, active-low
//   bus    drain_and_depressurize_if.slave (requests, sensors, outputs)
// Moore machine: every output decodes from the state register alone.
// ---------------------------------------------------------------------------
module drain_and_depressurize
    import airlock_pkg::*;
#(
    parameter int DRAIN_CYCLES = DEFAULT_DRAIN_CYCLES,
    parameter int VENT_TIMEOUT = DEFAULT_VENT_TIMEOUT
) (
    input logic                     Clock,
    input logic                     Reset,
    drain_and_depressurize_if.slave bus
);

    localparam int CNT_W = $clog2(max_int(DRAIN_CYCLES, VENT_TIMEOUT));

    localparam logic [2:0] S_IDLE  = IDLE;
    localparam logic [2:0] S_DRAIN = DRAIN;
    localparam logic [2:0] S_VENT  = VENT;
    localparam logic [2:0] S_DONE  = DONE;
    localparam logic [2:0] S_FAULT = FAULT;

    logic [2:0]       state_q;
    logic [2:0]       state_d;
    logic [CNT_W-1:0] count;
    logic             doors_ok;
    logic             cnt_clear;
    logic             cnt_enable;

    assign doors_ok = bus.InnerClosed & bus.OuterClosed;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                // A request with a door open or FandP low is simply ignored.
                if (bus.begin_DandD && bus.FandP && doors_ok) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!doors_ok) begin
                    state_d = S_FAULT;
                end else if (count == CNT_W'(DRAIN_CYCLES - 1)) begin
                    state_d = S_VENT;
                end
            end
            S_VENT: begin
                // Sensor confirmation beats the timeout on the same cycle.
                if (!doors_ok) begin
                    state_d = S_FAULT;
                end else if (bus.Depressurized) begin
                    state_d = S_DONE;
                end else if (count == CNT_W'(VENT_TIMEOUT - 1)) begin
                    state_d = S_FAULT;
                end
            end
            S_DONE: begin
                // A door opening here means the airlock has been used.
                if (!doors_ok) begin
                    state_d = S_IDLE;
                end
            end
            S_FAULT: state_d = S_FAULT;
            // Unused encodings indicate corruption; park in the fault state.
            default: state_d = S_FAULT;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The counter zeroes on reset and on every state change. It only runs in
    // the timed states, so it rests at zero in IDLE/DONE/FAULT and can never
    // wrap: both terminal counts force a state change first.
    assign cnt_clear  = !Reset || (state_d != state_q);
    assign cnt_enable = (state_q == S_DRAIN) || (state_q == S_VENT);

    cycle_counter #(
        .WIDTH (CNT_W)
    ) u_cycle_counter (
        .Clock  (Clock),
        .clear  (cnt_clear),
        .enable (cnt_enable),
        .count  (count)
    );

    assign bus.Draining = (state_q == S_DRAIN);
    assign bus.Venting  = (state_q == S_VENT);
    assign bus.DandD    = (state_q == S_DONE);
    assign bus.Fault    = (state_q == S_FAULT);

endmodule
